ss_count_checker: RTL and testbench
===================================

Name: ss_count_checker

Overview:
- Receive-side monitor for the four-digit seven-segment display bus (ss3..ss0) driven by the lab counter designs.
- Samples the segment patterns, filters glitches and decodes each glyph back to a nibble.
- Checks that each new stable displayed value is the previous value plus one, and reports per-step pass/fail pulses and a saturating error count.
- Used as a self-checking monitor in benches, and on-board to drive LEDs.

Parameters:
- MODULUS, 10, digit radix: 10 = BCD (digits A–F illegal), 16 = hex.
- STABLE_CYCLES, 2, consecutive identical decoded samples needed to accept a value; legal range is 2 or more.
- ERR_W, 8, width of err_cnt.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset (clears all state when 0)
- en  in  1  checking enable
- err_clr  in  1  synchronous clear of err_cnt
- ss3  in  7  most significant digit segments, active-low, bit order {g,f,e,d,c,b,a}
- ss2  in  7  digit 2 segments
- ss1  in  7  digit 1 segments
- ss0  in  7  least significant digit segments
- value  out  16  last accepted value, {d3,d2,d1,d0} nibbles
- valid  out  1  value holds an accepted reading
- locked  out  1  state is TRACK
- step_ok  out  1  one-cycle pulse: accepted value equals previous value + 1
- step_err  out  1  one-cycle pulse: accepted value differs from previous value + 1
- glyph_err  out  1  level: illegal pattern currently stable on some digit
- err_cnt  out  ERR_W  saturating count of step_err pulses

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: value=0, valid=0, locked=0, step_ok=0, step_err=0, glyph_err=0, err_cnt=0.
  - Internals: input register=7'h7F per digit (blank), candidate=0, stability count=0, state=IDLE.
  - Reset asserted mid-operation clears all of the above immediately.
- Legal glyphs:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
  - 7F is blank: not an error, but it blocks acceptance.
  - Any other pattern, or a digit ≥ MODULUS, is illegal.
- Pipeline:
  - Pins are registered at every edge.
  - The registered pins are decoded combinationally into a candidate word.
  - If the decode differs from the stored candidate, the candidate is loaded and the count is set to 1. If it matches, the count increments, saturating at STABLE_CYCLES.
- Acceptance:
  - Condition: decode equals candidate, count = STABLE_CYCLES−1, all digits legal and non-blank.
  - Latency: a pattern first captured at edge E0 and held steady is accepted at edge E0+STABLE_CYCLES.
  - Each stable value is accepted exactly once; saturation prevents re-acceptance.
  - A change lasting fewer than STABLE_CYCLES samples is never accepted.
- glyph_err: set when an illegal pattern reaches the same stability condition; cleared when a legal or blank word does.
- FSM:
  - IDLE: locked=0, no pulses. Exit to ACQUIRE when en=1.
  - ACQUIRE: on acceptance, value is loaded, valid=1, go to TRACK. No pulse is issued.
  - TRACK, on acceptance:
    - If accepted == value: no action.
    - If accepted == inc(value): step_ok.
    - Otherwise: step_err and err_cnt+1 (saturates at all-ones).
    - value is loaded in every case (resync); stay in TRACK.
  - TRACK, on glyph_err rising: go to ACQUIRE. valid and value are held.
  - Any state with en=0: go to IDLE at the next edge. value, valid and err_cnt are held.
- inc():
  - MODULUS=10: per-digit BCD increment with carry; 9999 wraps to 0000.
  - MODULUS=16: +1 mod 2^16; FFFF wraps to 0000.
- Pulses and errors:
  - step_ok and step_err are registered and mutually exclusive.
  - err_clr has priority over a same-cycle step_err: the count becomes 0.

Decomposition:
- Package ss_pkg holds:
  - the 16 glyph constants and SEG_BLANK;
  - the FSM state enum {IDLE, ACQUIRE, TRACK};
  - the glyph-class encoding {LEGAL, BLANK, ILLEGAL}.
- One sub-module, ss_glyph_decode: combinational, 7-bit pattern plus MODULUS in, nibble and class out; instantiated four times.

Test Plan:
1. Reset low then released, en=1, all digits = 40 held → at E0+2: valid=1, value=0000, locked=1; no step pulses.
2. From 0000, ss0=79 held 3 cycles → exactly one step_ok, value=0001, err_cnt=0.
3. BCD carry and wrap: 0009→0010 and 9999→0000 (ss3..ss0=40) → one step_ok each.
4. Jump 0003→0005 → step_err, err_cnt=1, value=0005; then 0006 → step_ok. err_clr the same cycle as a further step_err → err_cnt=0.
5. Glitches:
   - ss0 = 24 for 1 cycle, then back → no acceptance, no pulse.
   - ss0 = 7E for 2 cycles → glyph_err=1, locked=0. Restore 0007 → glyph_err=0, re-lock with no pulse.
6. rst driven low mid-TRACK between edges → all outputs 0 immediately, before the next clk edge; release → reacquire as in 1.

Source files
------------

// File: rtl/ss_pkg.sv
// Shared definitions for the seven-segment count checker: glyph patterns,
// FSM states, glyph classes and the displayed-value increment rule.
package ss_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACQUIRE = 2'd1,
      TRACK   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      LEGAL   = 2'd0,
      BLANK   = 2'd1,
      ILLEGAL = 2'd2
   } glyph_cls_e;

   // One decoded display word: per-digit class plus the four nibbles.
   typedef struct packed {
      logic [3:0][1:0] cls;
      logic [15:0]     value;
   } cand_t;

   function automatic logic [15:0] inc_value(input logic [15:0] v, input int modulus);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      if (modulus == 16) begin
         r = v + 16'd1;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (v[i*4 +: 4] == 4'd9) begin
                  r[i*4 +: 4] = 4'd0;
               end else begin
                  r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                  carry       = 1'b0;
               end
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ss_glyph_decode.sv
// Maps one active-low segment pattern back to its nibble and classifies it
// as a legal digit, blank, or illegal for the configured radix.
module ss_glyph_decode
   import ss_pkg::*;
#(
   parameter int MODULUS = 10
) (
   input  logic [6:0] seg_i,
   output logic [3:0] nibble_o,
   output glyph_cls_e cls_o
);

   logic known;

   always_comb begin
      nibble_o = 4'd0;
      known    = 1'b1;
      case (seg_i)
         SEG_0:   nibble_o = 4'h0;
         SEG_1:   nibble_o = 4'h1;
         SEG_2:   nibble_o = 4'h2;
         SEG_3:   nibble_o = 4'h3;
         SEG_4:   nibble_o = 4'h4;
         SEG_5:   nibble_o = 4'h5;
         SEG_6:   nibble_o = 4'h6;
         SEG_7:   nibble_o = 4'h7;
         SEG_8:   nibble_o = 4'h8;
         SEG_9:   nibble_o = 4'h9;
         SEG_A:   nibble_o = 4'hA;
         SEG_B:   nibble_o = 4'hB;
         SEG_C:   nibble_o = 4'hC;
         SEG_D:   nibble_o = 4'hD;
         SEG_E:   nibble_o = 4'hE;
         SEG_F:   nibble_o = 4'hF;
         default: known    = 1'b0;
      endcase
   end

   // A well-formed glyph above the radix (A-F in BCD) is still illegal.
   always_comb begin
      if (seg_i == SEG_BLANK) begin
         cls_o = BLANK;
      end else if (!known || ({1'b0, nibble_o} >= 5'(MODULUS))) begin
         cls_o = ILLEGAL;
      end else begin
         cls_o = LEGAL;
      end
   end

endmodule

// File: rtl/ss_count_checker.sv
// Receive-side monitor for a four-digit seven-segment counter display:
// filters glitches, decodes each digit and checks every new value is prev+1.
module ss_count_checker
   import ss_pkg::*;
#(
   parameter int MODULUS       = 10,
   parameter int STABLE_CYCLES = 2,
   parameter int ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             err_clr,
   input  logic [6:0]       ss3,
   input  logic [6:0]       ss2,
   input  logic [6:0]       ss1,
   input  logic [6:0]       ss0,
   output logic [15:0]      value,
   output logic             valid,
   output logic             locked,
   output logic             step_ok,
   output logic             step_err,
   output logic             glyph_err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int                CNT_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0]  CNT_HIT = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_SAT = CNT_W'(STABLE_CYCLES);

   logic [3:0][6:0]  pins_q, pins_d;
   logic [3:0]       dec_nib [4];
   glyph_cls_e       dec_cls [4];
   cand_t            dec;
   cand_t            cand_q, cand_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             same, stable_hit, any_illegal, any_blank, accept;
   logic             glyph_err_q, glyph_err_d, glyph_rise;
   state_e           state_q, state_d;
   logic             load_value;
   logic [15:0]      value_q, value_d;
   logic             valid_q, valid_d;
   logic             step_ok_q, step_ok_d;
   logic             step_err_q, step_err_d;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   assign pins_d = {ss3, ss2, ss1, ss0};

   for (genvar g = 0; g < 4; g++) begin : g_dec
      ss_glyph_decode #(
         .MODULUS (MODULUS)
      ) u_dec (
         .seg_i    (pins_q[g]),
         .nibble_o (dec_nib[g]),
         .cls_o    (dec_cls[g])
      );
   end

   always_comb begin
      dec         = '0;
      any_illegal = 1'b0;
      any_blank   = 1'b0;
      for (int g = 0; g < 4; g++) begin
         dec.value[g*4 +: 4] = dec_nib[g];
         dec.cls[g]          = dec_cls[g];
         any_illegal         = any_illegal | (dec_cls[g] == ILLEGAL);
         any_blank           = any_blank | (dec_cls[g] == BLANK);
      end
   end

   // Count saturates at STABLE_CYCLES so a held word hits exactly once.
   always_comb begin
      same       = (dec == cand_q);
      stable_hit = same && (cnt_q == CNT_HIT);
      accept     = stable_hit && !any_illegal && !any_blank;
      cand_d     = cand_q;
      cnt_d      = cnt_q;
      if (!same) begin
         cand_d = dec;
         cnt_d  = CNT_W'(1);
      end else if (cnt_q != CNT_SAT) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      glyph_err_d = stable_hit ? any_illegal : glyph_err_q;
      glyph_rise  = glyph_err_d && !glyph_err_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (!en) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = ACQUIRE;
            ACQUIRE: if (accept) state_d = TRACK;
            TRACK:   if (glyph_rise) state_d = ACQUIRE;
            default: state_d = IDLE;
         endcase
      end
   end

   // TRACK always resyncs to the accepted word; only the step check varies.
   always_comb begin
      locked     = (state_q == TRACK);
      load_value = 1'b0;
      step_ok_d  = 1'b0;
      step_err_d = 1'b0;
      if (en && accept) begin
         case (state_q)
            ACQUIRE: load_value = 1'b1;
            TRACK: begin
               load_value = 1'b1;
               if (dec.value != value_q) begin
                  if (dec.value == inc_value(value_q, MODULUS)) begin
                     step_ok_d = 1'b1;
                  end else begin
                     step_err_d = 1'b1;
                  end
               end
            end
            default: load_value = 1'b0;
         endcase
      end
   end

   always_comb begin
      value_d   = load_value ? dec.value : value_q;
      valid_d   = valid_q | load_value;
      err_cnt_d = err_cnt_q;
      if (err_clr) begin
         err_cnt_d = '0;
      end else if (step_err_d && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pins_q      <= {4{SEG_BLANK}};
         cand_q      <= '0;
         cnt_q       <= '0;
         glyph_err_q <= 1'b0;
         value_q     <= '0;
         valid_q     <= 1'b0;
         step_ok_q   <= 1'b0;
         step_err_q  <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         pins_q      <= pins_d;
         cand_q      <= cand_d;
         cnt_q       <= cnt_d;
         glyph_err_q <= glyph_err_d;
         value_q     <= value_d;
         valid_q     <= valid_d;
         step_ok_q   <= step_ok_d;
         step_err_q  <= step_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign value     = value_q;
   assign valid     = valid_q;
   assign step_ok   = step_ok_q;
   assign step_err  = step_err_q;
   assign glyph_err = glyph_err_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ss_count_checker.sv
// Bench for ss_count_checker: directed scenarios plus random display traffic,
// all compared against a run-length / integer-arithmetic reference model.
module tb_ss_count_checker;

   localparam int MOD = 10;
   localparam int SC  = 2;
   localparam int EW  = 3;
   localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b0;
   logic          err_clr = 1'b0;
   logic [6:0]    ss3 = 7'h7F, ss2 = 7'h7F, ss1 = 7'h7F, ss0 = 7'h7F;
   logic [15:0]   value;
   logic          valid, locked, step_ok, step_err, glyph_err;
   logic [EW-1:0] err_cnt;

   int checks = 0;
   int errors = 0;
   int n_ok, n_err;

   ss_count_checker #(
      .MODULUS       (MOD),
      .STABLE_CYCLES (SC),
      .ERR_W         (EW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .err_clr   (err_clr),
      .ss3       (ss3),
      .ss2       (ss2),
      .ss1       (ss1),
      .ss0       (ss0),
      .value     (value),
      .valid     (valid),
      .locked    (locked),
      .step_ok   (step_ok),
      .step_err  (step_err),
      .glyph_err (glyph_err),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   wire [20+EW:0] act_vec = {value, valid, locked, step_ok, step_err, glyph_err, err_cnt};

   // ---------------- reference model ----------------
   logic [27:0] m_sample, m_last;
   bit          m_have;
   int          m_run;
   int          m_mode;  // 0 idle, 1 acquiring, 2 tracking
   logic [15:0] m_value;
   bit          m_valid, m_ok, m_err, m_gerr;
   int          m_cnt;
   bit          mh_hit, mh_bad, mh_blank, mh_nge, mh_rise;
   logic [15:0] mh_acc;

   function automatic int glyph_val(input logic [6:0] s);
      for (int k = 0; k < 16; k++) if (s == GLYPH[k]) return k;
      if (s == 7'h7F) return 16;
      return -1;
   endfunction

   function automatic int bcd_to_int(input logic [15:0] v);
      return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
   endfunction

   function automatic logic [15:0] int_to_bcd(input int n);
      logic [15:0] r;
      r[15:12] = 4'((n / 1000) % 10);
      r[11:8]  = 4'((n / 100) % 10);
      r[7:4]   = 4'((n / 10) % 10);
      r[3:0]   = 4'(n % 10);
      return r;
   endfunction

   function automatic logic [15:0] next_of(input logic [15:0] v);
      if (MOD == 16) return v + 16'd1;
      return int_to_bcd((bcd_to_int(v) + 1) % 10000);
   endfunction

   task automatic analyse(input logic [27:0] w, output bit bad, output bit blank,
                          output logic [15:0] val);
      int d;
      bad = 0; blank = 0; val = '0;
      for (int k = 0; k < 4; k++) begin
         d = glyph_val(w[k*7 +: 7]);
         if (d == 16) blank = 1;
         else if (d < 0 || d >= MOD) bad = 1;
         else val[k*4 +: 4] = 4'(d);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_sample = {4{7'h7F}}; m_last = '0; m_have = 0; m_run = 0; m_mode = 0;
         m_value = '0; m_valid = 0; m_ok = 0; m_err = 0; m_gerr = 0; m_cnt = 0;
      end else begin
         if (m_have && m_sample == m_last) begin
            if (m_run < 1000) m_run++;
         end else begin
            m_run = 1;
         end
         m_last = m_sample;
         m_have = 1;
         mh_hit = (m_run == SC);
         analyse(m_sample, mh_bad, mh_blank, mh_acc);
         mh_nge  = mh_hit ? mh_bad : m_gerr;
         mh_rise = mh_nge && !m_gerr;
         m_ok = 0; m_err = 0;
         if (!en) m_mode = 0;
         else if (m_mode == 0) m_mode = 1;
         else if (mh_hit && !mh_bad && !mh_blank) begin
            if (m_mode == 2 && mh_acc != m_value) begin
               if (mh_acc == next_of(m_value)) m_ok = 1; else m_err = 1;
            end
            m_value = mh_acc; m_valid = 1; m_mode = 2;
         end else if (m_mode == 2 && mh_rise) m_mode = 1;
         if (err_clr) m_cnt = 0;
         else if (m_err && m_cnt < (1 << EW) - 1) m_cnt++;
         m_gerr   = mh_nge;
         m_sample = {ss3, ss2, ss1, ss0};
      end
   end

   function automatic logic [20+EW:0] exp_vec();
      return {m_value, m_valid, 1'(m_mode == 2), m_ok, m_err, m_gerr, EW'(m_cnt)};
   endfunction

   // ---------------- drivers ----------------
   task automatic cycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_word(input logic [15:0] w);
      ss3 = GLYPH[w[15:12]]; ss2 = GLYPH[w[11:8]]; ss1 = GLYPH[w[7:4]]; ss0 = GLYPH[w[3:0]];
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      #1 rst = 1'b0;
      #2;
      checks++;
      if (act_vec !== '0) begin
         errors++; $display("FAIL reset_outputs got=%h exp=0", act_vec);
      end
      @(negedge clk);
      rst = 1'b1; en = 1'b1; set_word(16'h0000);
      for (int c = 0; c < 3; c++) begin
         cycle(); checks++;
         if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_acquire c=%0d got=%h exp=%h", c, act_vec, exp_vec());
         end
         if (c == 1) begin
            checks++;
            if (valid !== 1'b0 || locked !== 1'b0) begin
               errors++; $display("FAIL early_accept valid=%b locked=%b exp 0 0", valid, locked);
            end
         end
      end
      checks++;
      if ({valid, locked, value, step_ok, step_err} !== {1'b1, 1'b1, 16'h0000, 2'b00}) begin
         errors++;
         $display("FAIL first_lock valid=%b locked=%b value=%h ok=%b err=%b exp 1 1 0000 0 0",
                  valid, locked, value, step_ok, step_err);
      end
   endtask

   task automatic test_step();
      n_ok = 0; n_err = 0;
      set_word(16'h0001);
      for (int c = 0; c < 3; c++) begin
         cycle(); checks++;
         if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL step got=%h exp=%h", act_vec, exp_vec());
         end
         n_ok += int'(step_ok); n_err += int'(step_err);
      end
      checks++;
      if (n_ok != 1 || n_err != 0 || value !== 16'h0001 || err_cnt !== '0) begin
         errors++;
         $display("FAIL step_one ok=%0d err=%0d value=%h cnt=%0d exp 1 0 0001 0", n_ok, n_err, value, err_cnt);
      end
   endtask

   task automatic test_carry();
      logic [15:0] seq [4];
      seq = '{16'h0009, 16'h0010, 16'h9999, 16'h0000};
      for (int s = 0; s < 4; s++) begin
         n_ok = 0;
         set_word(seq[s]);
         for (int c = 0; c < 3; c++) begin
            cycle(); checks++;
            if (act_vec !== exp_vec()) begin
               errors++; $display("FAIL carry w=%h got=%h exp=%h", seq[s], act_vec, exp_vec());
            end
            n_ok += int'(step_ok);
         end
         if (s == 1 || s == 3) begin
            checks++;
            if (n_ok != 1 || value !== seq[s]) begin
               errors++; $display("FAIL carry_ok w=%h ok=%0d value=%h exp 1 %h", seq[s], n_ok, value, seq[s]);
            end
         end
      end
      checks++;
      if (err_cnt !== EW'(2)) begin
         errors++; $display("FAIL carry_errcnt got=%0d exp=2", err_cnt);
      end
   endtask

   task automatic test_step_err();
      set_word(16'h0003);
      repeat (3) cycle();
      err_clr = 1'b1; cycle(); err_clr = 1'b0;
      checks++;
      if (act_vec !== exp_vec() || err_cnt !== '0) begin
         errors++; $display("FAIL err_clear got=%h exp=%h", act_vec, exp_vec());
      end
      n_ok = 0; n_err = 0;
      set_word(16'h0005);
      for (int c = 0; c < 3; c++) begin
         cycle(); checks++;
         if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL jump got=%h exp=%h", act_vec, exp_vec());
         end
         n_ok += int'(step_ok); n_err += int'(step_err);
      end
      checks++;
      if (n_ok != 0 || n_err != 1 || err_cnt !== EW'(1) || value !== 16'h0005) begin
         errors++;
         $display("FAIL jump_err ok=%0d err=%0d cnt=%0d value=%h exp 0 1 1 0005", n_ok, n_err, err_cnt, value);
      end
      n_ok = 0;
      set_word(16'h0006);
      repeat (3) begin cycle(); n_ok += int'(step_ok); end
      checks++;
      if (n_ok != 1 || act_vec !== exp_vec()) begin
         errors++; $display("FAIL after_jump ok=%0d got=%h exp=%h", n_ok, act_vec, exp_vec());
      end
      n_err = 0;
      err_clr = 1'b1; set_word(16'h0009);
      repeat (3) begin cycle(); n_err += int'(step_err); end
      err_clr = 1'b0;
      checks++;
      if (n_err != 1 || err_cnt !== '0) begin
         errors++; $display("FAIL clr_priority err=%0d cnt=%0d exp 1 0", n_err, err_cnt);
      end
   endtask

   task automatic test_back_to_back();
      n_ok = 0; n_err = 0;
      for (int w = 16'h0010; w <= 16'h0015; w++) begin
         set_word(16'(w));
         repeat (2) begin
            cycle(); checks++;
            if (act_vec !== exp_vec()) begin
               errors++; $display("FAIL b2b w=%h got=%h exp=%h", w, act_vec, exp_vec());
            end
            n_ok += int'(step_ok); n_err += int'(step_err);
         end
      end
      cycle(); n_ok += int'(step_ok); n_err += int'(step_err);
      checks++;
      if (n_ok != 6 || n_err != 0) begin
         errors++; $display("FAIL b2b_count ok=%0d err=%0d exp 6 0", n_ok, n_err);
      end
   endtask

   task automatic test_glitch();
      set_word(16'h0016);
      repeat (3) cycle();
      n_ok = 0; n_err = 0;
      ss0 = GLYPH[2];
      cycle(); n_ok += int'(step_ok); n_err += int'(step_err);
      set_word(16'h0016);
      repeat (3) begin cycle(); n_ok += int'(step_ok); n_err += int'(step_err); end
      checks++;
      if (n_ok != 0 || n_err != 0 || value !== 16'h0016 || act_vec !== exp_vec()) begin
         errors++; $display("FAIL short_glitch ok=%0d err=%0d value=%h exp 0 0 0016", n_ok, n_err, value);
      end
      ss0 = 7'h7E;
      repeat (2) cycle();
      set_word(16'h0017);
      cycle();
      checks++;
      if (glyph_err !== 1'b1 || locked !== 1'b0 || act_vec !== exp_vec()) begin
         errors++; $display("FAIL glyph_detect gerr=%b locked=%b exp 1 0", glyph_err, locked);
      end
      n_ok = 0; n_err = 0;
      repeat (2) begin cycle(); n_ok += int'(step_ok); n_err += int'(step_err); end
      cycle(); n_ok += int'(step_ok); n_err += int'(step_err);
      checks++;
      if (glyph_err !== 1'b0 || locked !== 1'b1 || value !== 16'h0017 || n_ok != 0 || n_err != 0) begin
         errors++;
         $display("FAIL relock gerr=%b locked=%b value=%h ok=%0d err=%0d exp 0 1 0017 0 0",
                  glyph_err, locked, value, n_ok, n_err);
      end
   endtask

   task automatic test_enable();
      en = 1'b0;
      cycle();
      checks++;
      if (locked !== 1'b0 || valid !== 1'b1 || value !== 16'h0017 || act_vec !== exp_vec()) begin
         errors++; $display("FAIL disable locked=%b valid=%b value=%h exp 0 1 0017", locked, valid, value);
      end
      en = 1'b1;
      n_ok = 0;
      set_word(16'h0018);
      repeat (4) begin cycle(); n_ok += int'(step_ok); end
      checks++;
      if (locked !== 1'b1 || value !== 16'h0018 || n_ok != 0) begin
         errors++; $display("FAIL reenable locked=%b value=%h ok=%0d exp 1 0018 0", locked, value, n_ok);
      end
   endtask

   task automatic test_async_reset();
      #2 rst = 1'b0;
      #1;
      checks++;
      if (act_vec !== '0) begin
         errors++; $display("FAIL async_reset got=%h exp=0", act_vec);
      end
      @(negedge clk);
      rst = 1'b1; set_word(16'h0000);
      repeat (3) begin
         cycle(); checks++;
         if (act_vec !== exp_vec()) begin
            errors++; $display("FAIL reacquire got=%h exp=%h", act_vec, exp_vec());
         end
      end
      checks++;
      if (valid !== 1'b1 || locked !== 1'b1 || value !== 16'h0000) begin
         errors++; $display("FAIL reacquire_lock valid=%b locked=%b value=%h exp 1 1 0000", valid, locked, value);
      end
   endtask

   task automatic test_random();
      logic [15:0] cur;
      logic [6:0]  d [4];
      int          kind, hold;
      cur = 16'h0000;
      for (int it = 0; it < 300; it++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 3) cur = next_of(cur);
         else if (kind == 5) cur = int_to_bcd($urandom_range(0, 9999));
         for (int k = 0; k < 4; k++) d[k] = GLYPH[cur[k*4 +: 4]];
         if (kind == 6) d[$urandom_range(0, 3)] = 7'h7F;
         if (kind == 7) d[$urandom_range(0, 3)] = 7'h7E;
         if (kind == 8) d[$urandom_range(0, 3)] = GLYPH[$urandom_range(10, 15)];
         {ss3, ss2, ss1, ss0} = {d[3], d[2], d[1], d[0]};
         en      = ($urandom_range(0, 19) != 0);
         err_clr = ($urandom_range(0, 15) == 0);
         hold    = $urandom_range(1, 4);
         repeat (hold) begin
            cycle(); checks++;
            if (act_vec !== exp_vec()) begin
               errors++; $display("FAIL random it=%0d got=%h exp=%h", it, act_vec, exp_vec());
            end
         end
      end
      en = 1'b1; err_clr = 1'b0;
   endtask

   initial begin
      test_reset();
      test_step();
      test_carry();
      test_step_err();
      test_back_to_back();
      test_glitch();
      test_enable();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
